arith_arbiter: RTL and testbench
================================

Name: arith_arbiter

Overview:
- Shares the single slowmpy multiplier and the single div divider between NREQ requesters, e.g. the vertex transform and perspective-divide stages.
- Accepts one operation at a time: a multiply or a Q-format divide.
- Arbitrates round-robin, sequences the unit's start pulse, waits for completion and returns the result with a one-cycle response strobe.
- Sits between the requester FSMs in the top level and the two arithmetic units.

Parameters:
- NREQ, 2, number of requesters (2..4).
- TIMEOUT, 63, WAIT-state cycle limit; used only when the watchdog is compiled in.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request level
- op  in  NREQ  per-requester op: 0=mul, 1=div
- req_a  in  32*NREQ  operand A, requester i at [32i+31:32i]
- req_b  in  32*NREQ  operand B, same packing
- gnt  out  NREQ  one-hot; high from grant until the response cycle inclusive
- rsp_valid  out  NREQ  one-hot, one-cycle result strobe
- rsp_data  out  32  result; valid only while rsp_valid!=0
- rsp_err  out  1  error flag qualified by rsp_valid
- mul_stb  out  1  start pulse to slowmpy
- mul_a  out  16  multiplier A (low 16 bits of the latched operand)
- mul_b  out  16  multiplier B (low 16 bits of the latched operand)
- mul_busy  in  1  multiplier busy
- mul_done  in  1  multiplier done
- mul_p  in  32  signed product
- div_start  out  1  start pulse to div
- div_a  out  32  dividend
- div_b  out  32  divisor
- div_busy  in  1  divider busy
- div_done  in  1  divider done
- div_valid  in  1  divider result valid
- div_dbz  in  1  divide by zero
- div_ovf  in  1  divider overflow
- div_val  in  32  quotient

Behaviour:
- All outputs are registered.
- Reset values:
  - gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0.
  - mul_stb=0, div_start=0; operand registers 0.
  - State IDLE; last-grant pointer = NREQ-1, so requester 0 wins first.
- Reset mid-operation: return to IDLE immediately and drop the pending op; the arithmetic units share the same reset.
- States and transitions:
  - IDLE: if req!=0, select the first set bit searching from last+1 with wrap. Latch index, op, A and B. Set gnt one-hot next cycle. Go to ISSUE.
  - ISSUE: hold while the target unit's busy=1. When busy=0, assert mul_stb or div_start for exactly one cycle. Go to WAIT.
  - WAIT: on the target unit's done (mul_done for mul, div_done for div), latch the result. Go to RESP. The other unit's done is ignored, as is any done seen outside WAIT.
  - RESP: rsp_valid[idx]=1 for one cycle with rsp_data and rsp_err. Next cycle: gnt=0, last=idx, back to IDLE.
- Result rules:
  - Mul: rsp_data = mul_p (full 32-bit signed product, no rescaling); rsp_err=0.
  - Div: rsp_data = div_val; rsp_err = div_dbz | div_ovf | ~div_valid.
- Requester contract:
  - Hold req, op and operands until its rsp_valid.
  - Operands are latched at grant; later changes have no effect.
  - Dropping req after grant does not abort; the response is still delivered.
  - req may be reasserted in the cycle after rsp_valid.
- Fairness: with all requesters requesting continuously, grants rotate 0,1,..,NREQ-1. Minimum gap from a request to its rsp_valid is 3 cycles plus the unit latency.
- Only one op is in flight at a time; the second unit idles while the first works.

Optional Feature:
- Macro: ARITH_ARB_TIMEOUT_EN.
- Defined: an 8-bit counter clears on WAIT entry and increments each WAIT cycle. When it reaches TIMEOUT without done, go to RESP with rsp_data=0 and rsp_err=1; a late done from that op is ignored.
- Undefined: no counter; WAIT waits indefinitely.

Test Plan:
- Req0 mul, A=0xFFFFEC14 (-5100), B=0xFFFFFE0C (-500) -> mul_a=0xEC14, mul_b=0xFE0C, one mul_stb pulse; rsp_valid=01, rsp_data=0x0026E8F0, rsp_err=0.
- Req1 div, A=0x00800000, B=0x000F0000 (Q16: 128/15) -> one div_start pulse; rsp_valid=10, rsp_data=0x00088888, rsp_err=0.
- Req0 div with B=0 -> rsp_err=1; the arbiter returns to IDLE and serves the next request.
- Both req held continuously for 4 ops -> gnt sequence 01,10,01,10; never two bits set; each op gets exactly one start pulse.
- Reset asserted in WAIT, then released -> all outputs 0; the next request from req1 alone is granted with fresh operands.
- With ARITH_ARB_TIMEOUT_EN, TIMEOUT=10, unit model never asserts done -> rsp_valid after 10 WAIT cycles, rsp_data=0, rsp_err=1.

Source files
------------

// File: rtl/arith_arbiter.sv
// Round-robin arbiter sharing one slowmpy multiplier and one div divider between NREQ requesters.
// Optional WAIT watchdog compiled in with `define ARITH_ARB_TIMEOUT_EN (limit set by TIMEOUT).
module arith_arbiter #(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 63
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      op,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [31:0]          rsp_data,
   output logic                 rsp_err,
   output logic                 mul_stb,
   output logic [15:0]          mul_a,
   output logic [15:0]          mul_b,
   input  logic                 mul_busy,
   input  logic                 mul_done,
   input  logic [31:0]          mul_p,
   output logic                 div_start,
   output logic [31:0]          div_a,
   output logic [31:0]          div_b,
   input  logic                 div_busy,
   input  logic                 div_done,
   input  logic                 div_valid,
   input  logic                 div_dbz,
   input  logic                 div_ovf,
   input  logic [31:0]          div_val,
   output logic [1:0]           dbg_state
);

   localparam int IDXW = (NREQ > 2) ? 2 : 1;

   if (NREQ < 2 || NREQ > 4 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
      $error("arith_arbiter: NREQ must be 2..4 and TIMEOUT 1..255");
   end

   // Handshake: requester holds req/op/operands until its rsp_valid; gnt is high from
   // the cycle after selection through the rsp_valid cycle; rsp_valid is a one-cycle strobe.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [IDXW-1:0]      idx_q, idx_d;
   logic [IDXW-1:0]      last_q, last_d;
   logic                 is_div_q, is_div_d;
   logic [31:0]          a_q, a_d;
   logic [31:0]          b_q, b_d;
   logic [NREQ-1:0]      gnt_q, gnt_d;
   logic [NREQ-1:0]      rsp_valid_q, rsp_valid_d;
   logic [31:0]          rsp_data_q, rsp_data_d;
   logic                 rsp_err_q, rsp_err_d;
   logic                 mul_stb_q, mul_stb_d;
   logic                 div_start_q, div_start_d;
`ifdef ARITH_ARB_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
   logic [7:0]           cnt_q, cnt_d;
`endif

   logic [31:0]          a_arr [NREQ];
   logic [31:0]          b_arr [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign a_arr[i] = req_a[32*i +: 32];
      assign b_arr[i] = req_b[32*i +: 32];
   end

   function automatic logic [NREQ-1:0] to_onehot(input logic [IDXW-1:0] i);
      logic [NREQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Round-robin pick: first set request searching upward from last+1, wrapping.
   int                   rr_cand;
   logic [IDXW-1:0]      rr_idx;
   logic                 sel_found;
   logic [IDXW-1:0]      sel_idx;

   always_comb begin
      rr_cand   = 0;
      rr_idx    = '0;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         rr_cand = (int'(last_q) + k) % NREQ;
         rr_idx  = IDXW'(rr_cand);
         if (!sel_found && req[rr_idx]) begin
            sel_found = 1'b1;
            sel_idx   = rr_idx;
         end
      end
   end

   logic unit_busy;
   logic unit_done;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      last_d      = last_q;
      is_div_d    = is_div_q;
      a_d         = a_q;
      b_d         = b_q;
      gnt_d       = gnt_q;
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      mul_stb_d   = 1'b0;
      div_start_d = 1'b0;
`ifdef ARITH_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      unit_busy   = is_div_q ? div_busy : mul_busy;
      unit_done   = is_div_q ? div_done : mul_done;

      case (state_q)
         S_IDLE: begin
            if (sel_found) begin
               idx_d    = sel_idx;
               is_div_d = op[sel_idx];
               a_d      = a_arr[sel_idx];
               b_d      = b_arr[sel_idx];
               gnt_d    = to_onehot(sel_idx);
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!unit_busy) begin
               mul_stb_d   = ~is_div_q;
               div_start_d = is_div_q;
               state_d     = S_WAIT;
`ifdef ARITH_ARB_TIMEOUT_EN
               cnt_d       = '0;
`endif
            end
         end
         S_WAIT: begin
            if (unit_done) begin
               rsp_valid_d = to_onehot(idx_q);
               rsp_data_d  = is_div_q ? div_val : mul_p;
               rsp_err_d   = is_div_q & (div_dbz | div_ovf | ~div_valid);
               state_d     = S_RESP;
            end
`ifdef ARITH_ARB_TIMEOUT_EN
            else if (cnt_q + 8'd1 == TIMEOUT_CNT) begin
               // Unit never answered: report an error; its late done lands outside WAIT.
               rsp_valid_d = to_onehot(idx_q);
               rsp_data_d  = '0;
               rsp_err_d   = 1'b1;
               state_d     = S_RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         S_RESP: begin
            gnt_d   = '0;
            last_d  = idx_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         last_q      <= IDXW'(NREQ - 1);
         is_div_q    <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         mul_stb_q   <= 1'b0;
         div_start_q <= 1'b0;
`ifdef ARITH_ARB_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         last_q      <= last_d;
         is_div_q    <= is_div_d;
         a_q         <= a_d;
         b_q         <= b_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         mul_stb_q   <= mul_stb_d;
         div_start_q <= div_start_d;
`ifdef ARITH_ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign mul_stb   = mul_stb_q;
   assign mul_a     = a_q[15:0];
   assign mul_b     = b_q[15:0];
   assign div_start = div_start_q;
   assign div_a     = a_q;
   assign div_b     = b_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_arith_arbiter.sv
// Self-checking bench for arith_arbiter: behavioural multiplier/divider models, directed
// vector table, hand sequences for multi-cycle corners, then randomized ops vs a reference model.
module tb_arith_arbiter;

   localparam int NREQ = 2;
`ifdef ARITH_ARB_TIMEOUT_EN
   localparam int TMO = 10;
`else
   localparam int TMO = 63;
`endif

   logic                 clk;
   logic                 reset;
   logic [NREQ-1:0]      req;
   logic [NREQ-1:0]      op;
   logic [32*NREQ-1:0]   req_a;
   logic [32*NREQ-1:0]   req_b;
   logic [NREQ-1:0]      gnt;
   logic [NREQ-1:0]      rsp_valid;
   logic [31:0]          rsp_data;
   logic                 rsp_err;
   logic                 mul_stb;
   logic [15:0]          mul_a;
   logic [15:0]          mul_b;
   logic                 mul_busy;
   logic                 mul_done;
   logic [31:0]          mul_p;
   logic                 div_start;
   logic [31:0]          div_a;
   logic [31:0]          div_b;
   logic                 div_busy;
   logic                 div_done;
   logic                 div_valid;
   logic                 div_dbz;
   logic                 div_ovf;
   logic [31:0]          div_val;
   logic [1:0]           dbg_state;

   arith_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .req(req), .op(op), .req_a(req_a), .req_b(req_b),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .mul_stb(mul_stb), .mul_a(mul_a), .mul_b(mul_b), .mul_busy(mul_busy),
      .mul_done(mul_done), .mul_p(mul_p), .div_start(div_start), .div_a(div_a),
      .div_b(div_b), .div_busy(div_busy), .div_done(div_done), .div_valid(div_valid),
      .div_dbz(div_dbz), .div_ovf(div_ovf), .div_val(div_val), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- arithmetic unit models ----------------
   int          mul_lat = 0, div_lat = 0;
   logic        mul_busy_ext = 0, div_busy_ext = 0, div_done_force = 0, div_never = 0;
   logic        m_busy, m_done;
   logic [31:0] m_res;
   int          m_cnt;
   logic        d_busy, d_done;
   logic [31:0] d_res;
   logic        d_res_dbz, d_res_ovf;
   int          d_cnt;

   always @(posedge clk) begin
      if (reset) begin
         m_busy <= 0; m_done <= 0; m_cnt <= 0; m_res <= '0; mul_p <= '0;
      end else begin
         m_done <= 0;
         if (mul_stb && !m_busy) begin
            m_busy <= 1;
            m_cnt  <= mul_lat;
            m_res  <= 32'(longint'($signed(mul_a)) * longint'($signed(mul_b)));
         end else if (m_busy) begin
            if (m_cnt == 0) begin
               m_busy <= 0; m_done <= 1; mul_p <= m_res;
            end else m_cnt <= m_cnt - 1;
         end
      end
   end

   always @(posedge clk) begin
      longint q;
      if (reset) begin
         d_busy <= 0; d_done <= 0; d_cnt <= 0; d_res <= '0; d_res_dbz <= 0; d_res_ovf <= 0;
         div_val <= '0; div_valid <= 0; div_dbz <= 0; div_ovf <= 0;
      end else begin
         d_done <= 0;
         if (div_start && !d_busy) begin
            d_busy <= 1;
            d_cnt  <= div_lat;
            if (div_b == 0) begin
               d_res <= '0; d_res_dbz <= 1; d_res_ovf <= 0;
            end else begin
               q = (longint'($signed(div_a)) <<< 16) / longint'($signed(div_b));
               d_res     <= q[31:0];
               d_res_dbz <= 0;
               d_res_ovf <= (q > 64'sd2147483647) || (q < -64'sd2147483648);
            end
         end else if (d_busy && !div_never) begin
            if (d_cnt == 0) begin
               d_busy <= 0; d_done <= 1; div_val <= d_res;
               div_dbz <= d_res_dbz; div_ovf <= d_res_ovf; div_valid <= !(d_res_dbz || d_res_ovf);
            end else d_cnt <= d_cnt - 1;
         end
      end
   end

   assign mul_busy = m_busy | mul_busy_ext;
   assign mul_done = m_done;
   assign div_busy = d_busy | div_busy_ext;
   assign div_done = d_done | div_done_force;

   // ---------------- checking helpers ----------------
   int checks = 0, failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [NREQ-1:0] oh(input int i);
      logic [NREQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Reference model: spec arithmetic on the operands the requester presented.
   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      longint p;
      p = longint'($signed(a[15:0])) * longint'($signed(b[15:0]));
      return p[31:0];
   endfunction

   task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] data, output logic err, output logic chk_data);
      longint q;
      data = '0; err = 1'b1; chk_data = 1'b0;
      if (b != 0) begin
         q = (longint'($signed(a)) * 64'sd65536) / longint'($signed(b));
         if (q <= 64'sd2147483647 && q >= -64'sd2147483648) begin
            data = q[31:0]; err = 1'b0; chk_data = 1'b1;
         end
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   // entry: {rid[35:34], chk_data[33], err[32], data[31:0]}
   logic [35:0] exp_q[$];
   logic [35:0] e;
   int          mul_stb_cnt = 0, div_start_cnt = 0, div_stb_cyc = 0;
   logic        mul_busy_s = 0, div_busy_s = 0;

   always @(posedge clk) begin
      mul_busy_s <= mul_busy;
      div_busy_s <= div_busy;
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (gnt != 0) chk("gnt_onehot", 32'($onehot(gnt)), 1);
         if (mul_stb) begin
            mul_stb_cnt++;
            chk("mul_stb_while_busy", 32'(mul_busy_s), 0);
         end
         if (div_start) begin
            div_start_cnt++;
            div_stb_cyc = cyc;
            chk("div_start_while_busy", 32'(div_busy_s), 0);
         end
         if (rsp_valid != 0) begin
            if (exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_rsp actual=%b required=none", rsp_valid);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_valid", 32'(rsp_valid), 32'(oh(int'(e[35:34]))));
               chk("gnt_at_rsp", 32'(gnt), 32'(rsp_valid));
               chk("rsp_err", 32'(rsp_err), 32'(e[32]));
               if (e[33]) chk("rsp_data", rsp_data, e[31:0]);
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic do_op(input int rid, input logic is_div, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_data, input logic exp_err,
                        input logic exp_chk, input int lat, input int busy_pre,
                        input bit drop, input bit chk_lat, output int rsp_cyc);
      int  ms0, ds0, n;
      bit  got, granted;
      mul_lat = lat; div_lat = lat;
      exp_q.push_back({2'(rid), exp_chk, exp_err, exp_data});
      ms0 = mul_stb_cnt; ds0 = div_start_cnt;
      got = 0; granted = 0; rsp_cyc = 0;
      @(negedge clk);
      req[rid] = 1'b1; op[rid] = is_div;
      req_a[32*rid +: 32] = a; req_b[32*rid +: 32] = b;
      if (busy_pre > 0) begin
         if (is_div) div_busy_ext = 1'b1; else mul_busy_ext = 1'b1;
      end
      for (n = 1; n <= 300; n++) begin
         @(negedge clk);
         if (n == busy_pre) begin mul_busy_ext = 1'b0; div_busy_ext = 1'b0; end
         if (!granted && gnt != 0) begin
            granted = 1;
            chk("gnt_grant", 32'(gnt), 32'(oh(rid)));
            // operands are latched at grant; scramble them to prove it
            req_a[32*rid +: 32] = ~a; req_b[32*rid +: 32] = ~b;
            if (drop) req[rid] = 1'b0;
         end
         if (rsp_valid[rid]) begin got = 1; rsp_cyc = cyc; break; end
      end
      req[rid] = 1'b0;
      mul_busy_ext = 1'b0; div_busy_ext = 1'b0;
      if (!got) begin
         checks++; failures++;
         $display("FAIL rsp_timeout actual=none required=rsp_valid[%0d]", rid);
         exp_q.delete();
      end
      chk(is_div ? "div_start_count" : "mul_stb_count", 32'(is_div ? div_start_cnt - ds0 : mul_stb_cnt - ms0), 1);
      chk(is_div ? "mul_stb_idle" : "div_start_idle", 32'(is_div ? mul_stb_cnt - ms0 : div_start_cnt - ds0), 0);
      if (chk_lat && got && busy_pre == 0) chk("latency", 32'(n), 32'(5 + lat));
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      int          rid;
      logic        is_div;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_data;
      logic        exp_err;
      logic        chk_data;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int          rc, gseen, rsps, ms0, rid, lat, bp;
      logic        dv, er, ck;
      logic [31:0] a, b, d;
      logic [NREQ-1:0] pg;
      logic [NREQ-1:0] gq[$];

      vecs[0] = '{0, 1'b0, 32'hFFFFEC14, 32'hFFFFFE0C, 32'h0026E8F0, 1'b0, 1'b1};
      vecs[1] = '{1, 1'b1, 32'h00800000, 32'h000F0000, 32'h00088888, 1'b0, 1'b1};
      vecs[2] = '{0, 1'b1, 32'h00010000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
      vecs[3] = '{1, 1'b0, 32'h00000003, 32'h12340007, 32'h00000015, 1'b0, 1'b1};
      vecs[4] = '{0, 1'b0, 32'h00007FFF, 32'h00008000, 32'hC0008000, 1'b0, 1'b1};
      vecs[5] = '{1, 1'b1, 32'h7FFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
      vecs[6] = '{0, 1'b1, 32'hFFFF0000, 32'h00020000, 32'hFFFF8000, 1'b0, 1'b1};

      reset = 1'b1; req = '0; op = '0; req_a = '0; req_b = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_gnt", 32'(gnt), 0);
      chk("reset_rsp_valid", 32'(rsp_valid), 0);
      chk("reset_rsp_data", rsp_data, 0);
      chk("reset_strobes", {30'd0, mul_stb, div_start}, 0);
      chk("reset_operands", {mul_a, mul_b} | div_a | div_b, 0);

      // directed table, exact latency checked
      for (int i = 0; i < 7; i++)
         do_op(vecs[i].rid, vecs[i].is_div, vecs[i].a, vecs[i].b, vecs[i].exp_data,
               vecs[i].exp_err, vecs[i].chk_data, i % 3, 0, 1'b0, 1'b1, rc);

      // other unit's done during a mul WAIT must be ignored
      fork
         do_op(0, 1'b0, 32'h00001234, 32'h00000100, 32'h00123400, 1'b0, 1'b1, 6, 0, 1'b0, 1'b1, rc);
         begin
            for (int i = 0; i < 50 && !mul_stb; i++) @(negedge clk);
            @(negedge clk);
            div_done_force = 1'b1;
            @(negedge clk);
            div_done_force = 1'b0;
         end
      join

      // reset while in WAIT drops the op
      mul_lat = 40;
      @(negedge clk);
      req[0] = 1'b1; op[0] = 1'b0; req_a[31:0] = 32'h00000777; req_b[31:0] = 32'h00000999;
      for (int i = 0; i < 50 && !mul_stb; i++) @(negedge clk);
      @(negedge clk);
      reset = 1'b1; req = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_gnt", 32'(gnt), 0);
      chk("rst_mid_rsp", {rsp_data[29:0], rsp_err, |rsp_valid}, 0);
      chk("rst_mid_strobes", {30'd0, mul_stb, div_start}, 0);
      chk("rst_mid_operands", {mul_a, mul_b} | div_a | div_b, 0);
      do_op(1, 1'b0, 32'h00000010, 32'h00000020, 32'h00000200, 1'b0, 1'b1, 1, 0, 1'b0, 1'b1, rc);

      // both requesters held: grants alternate 0,1,0,1
      mul_lat = 2;
      ms0 = mul_stb_cnt;
      for (int i = 0; i < 4; i++)
         exp_q.push_back({2'(i % 2), 1'b1, 1'b0, ref_mul(32'(100 + i % 2), 32'(-3 - i % 2))});
      @(negedge clk);
      op = '0; req_a = {32'd101, 32'd100}; req_b = {-32'sd4, -32'sd3}; req = '1;
      pg = '0; rsps = 0;
      for (int i = 0; i < 400 && rsps < 4; i++) begin
         @(negedge clk);
         if (pg == 0 && gnt != 0) gq.push_back(gnt);
         pg = gnt;
         if (rsp_valid != 0) rsps++;
      end
      req = '0;
      chk("rr_grant_count", 32'(gq.size()), 4);
      for (int i = 0; i < 4; i++) begin
         gseen = (i < gq.size()) ? int'(gq[i]) : 0;
         chk("rr_grant_seq", 32'(gseen), 32'(oh(i % 2)));
      end
      chk("rr_stb_count", 32'(mul_stb_cnt - ms0), 4);

      // randomized ops against the reference model
      for (int i = 0; i < 40; i++) begin
         rid = $urandom_range(0, NREQ - 1);
         dv  = 1'($urandom_range(0, 1));
         a   = $urandom; b = $urandom;
         lat = $urandom_range(0, 5);
         bp  = $urandom_range(0, 3);
         if (dv) begin
            case ($urandom_range(0, 7))
               0: b = '0;
               1, 2, 3, 4: begin
                  a = $urandom_range(0, 32'h00FFFFFF);
                  if ($urandom_range(0, 1) == 1) a = -a;
                  b = $urandom_range(1, 32'h00FFFFFF);
                  if ($urandom_range(0, 1) == 1) b = -b;
               end
               default: ;
            endcase
            ref_div(a, b, d, er, ck);
         end else begin
            d = ref_mul(a, b); er = 1'b0; ck = 1'b1;
         end
         do_op(rid, dv, a, b, d, er, ck, lat, bp, 1'($urandom_range(0, 1)), 1'b1, rc);
      end

`ifdef ARITH_ARB_TIMEOUT_EN
      // divider never answers: watchdog reports an error after TMO WAIT cycles
      div_never = 1'b1;
      do_op(0, 1'b1, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, rc);
      chk("timeout_wait_cycles", 32'(rc - div_stb_cyc), 32'(TMO));
`endif

      repeat (3) @(negedge clk);
      chk("exp_q_drained", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

endmodule
